ifu_fetch_unit: RTL and testbench

Instruction-fetch unit between the PC generator (upstream) and the decoder (IDU, downstream). It accepts PCs over a valid/ready handshake and issues an instruction-memory read for each PC on the bus. It pairs each returned instruction with its PC and forwards the pair in order to the IDU. On a control-transfer instruction it stalls until the branch resolves, then flushes wrong-path fetches if the branch redirected.

---
 rtl/ifu_fetch_unit_pkg.sv | 16 +
 rtl/ifu_sync_fifo.sv | 50 +++++
 rtl/ifu_fetch_unit.sv | 114 +++++++++++
 tb/tb_ifu_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: predecode opcodes and
// the fetch-control state encoding.
package ifu_fetch_unit_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        RX_PEND = 2'd0,
        TX_PEND = 2'd1,
        BC_PEND = 2'd2,
        FS_PEND = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifu_sync_fifo.sv
// Single-clock valid/ready FIFO; DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module ifu_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction-fetch unit: issues a bus read per accepted PC, pairs returned
// words with their PCs in order, and stalls/flushes around control transfers.
module ifu_fetch_unit
    import ifu_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ifu_rx_valid,
    output logic             ifu_rx_ready,
    input  logic [31:0]      ifu_rx_pc,
    output logic             ifu_tx_valid,
    input  logic             ifu_tx_ready,
    output logic [31:0]      ifu_tx_pc,
    output logic [31:0]      ifu_tx_inst,
    output logic             bus_req_valid,
    output logic [31:0]      bus_req_addr,
    input  logic             bus_rsp_valid,
    input  logic [31:0]      bus_rsp_data,
    input  logic             ifu_rx_pc_valid,
    input  logic             ifu_rx_bc_en,
    output ifu_state_e       dbg_state,
    output logic [CNT_W-1:0] dbg_occ
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid and its payload hold until that edge.

    ifu_state_e       state;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] occ_next;

    logic        pc_in_ready, pc_out_valid;
    logic        inst_in_ready, inst_out_valid;
    logic [31:0] pc_head, inst_head;
    logic        accept_state, rx_ena, hv, tx_ena, flush_pop, pop;
    logic        head_is_cti;

    // Queue space is implied by occ < DEPTH; the FIFO readies are redundant.
    assign accept_state = (state == RX_PEND) || (state == TX_PEND);
    assign ifu_rx_ready = accept_state & ifu_tx_ready & (occ < CNT_W'(DEPTH))
                          & pc_in_ready & inst_in_ready;
    assign rx_ena       = ifu_rx_valid & ifu_rx_ready;

    assign bus_req_valid = rx_ena;
    assign bus_req_addr  = ifu_rx_pc;

    assign hv           = pc_out_valid & inst_out_valid;
    assign ifu_tx_valid = hv & (state == TX_PEND);
    assign ifu_tx_pc    = pc_head;
    assign ifu_tx_inst  = inst_head;
    assign tx_ena       = ifu_tx_valid & ifu_tx_ready;
    assign flush_pop    = hv & (state == FS_PEND);
    assign pop          = tx_ena | flush_pop;

    assign occ_next = occ + CNT_W'(rx_ena) - CNT_W'(pop);

    assign head_is_cti = (inst_head[6:0] == OPC_JAL) ||
                         (inst_head[6:0] == OPC_JALR) ||
                         (inst_head[6:0] == OPC_BRANCH);

    assign dbg_state = state;
    assign dbg_occ   = occ;

    ifu_sync_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) u_pc_q (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (rx_ena),
        .in_ready  (pc_in_ready),
        .in_data   (ifu_rx_pc),
        .out_valid (pc_out_valid),
        .out_ready (pop),
        .out_data  (pc_head)
    );

    ifu_sync_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) u_inst_q (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (bus_rsp_valid),
        .in_ready  (inst_in_ready),
        .in_data   (bus_rsp_data),
        .out_valid (inst_out_valid),
        .out_ready (pop),
        .out_data  (inst_head)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RX_PEND;
            occ   <= '0;
        end else begin
            occ <= occ_next;
            case (state)
                RX_PEND: if (rx_ena) state <= TX_PEND;
                TX_PEND: begin
                    // The CTI leaves this cycle; younger fetches wait behind it.
                    if (tx_ena && head_is_cti) state <= BC_PEND;
                    else if (occ_next == '0)   state <= RX_PEND;
                end
                BC_PEND: begin
                    if (ifu_rx_pc_valid) begin
                        if (ifu_rx_bc_en)    state <= FS_PEND;
                        else if (occ != '0)  state <= TX_PEND;
                        else                 state <= RX_PEND;
                    end
                end
                FS_PEND: if (occ_next == '0) state <= RX_PEND;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Bench for ifu_fetch_unit: a bus responder with random latency, a branch
// resolver, and a scoreboard of expected in-order (pc, inst) deliveries.
module tb_ifu_fetch_unit;
    import ifu_fetch_unit_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rstn;
    logic             ifu_rx_valid;
    logic             ifu_rx_ready;
    logic [31:0]      ifu_rx_pc;
    logic             ifu_tx_valid;
    logic             ifu_tx_ready;
    logic [31:0]      ifu_tx_pc;
    logic [31:0]      ifu_tx_inst;
    logic             bus_req_valid;
    logic [31:0]      bus_req_addr;
    logic             bus_rsp_valid;
    logic [31:0]      bus_rsp_data;
    logic             ifu_rx_pc_valid;
    logic             ifu_rx_bc_en;
    ifu_state_e       dbg_state;
    logic [CNT_W-1:0] dbg_occ;

    ifu_fetch_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .ifu_rx_valid    (ifu_rx_valid),
        .ifu_rx_ready    (ifu_rx_ready),
        .ifu_rx_pc       (ifu_rx_pc),
        .ifu_tx_valid    (ifu_tx_valid),
        .ifu_tx_ready    (ifu_tx_ready),
        .ifu_tx_pc       (ifu_tx_pc),
        .ifu_tx_inst     (ifu_tx_inst),
        .bus_req_valid   (bus_req_valid),
        .bus_req_addr    (bus_req_addr),
        .bus_rsp_valid   (bus_rsp_valid),
        .bus_rsp_data    (bus_rsp_data),
        .ifu_rx_pc_valid (ifu_rx_pc_valid),
        .ifu_rx_bc_en    (ifu_rx_bc_en),
        .dbg_state       (dbg_state),
        .dbg_occ         (dbg_occ)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] imem[logic [31:0]];
    logic [31:0] rsp_pc_q[$];
    int          rsp_due_q[$];
    int          cyc = 0;
    int          lat_min = 2;
    int          lat_max = 2;
    bit          hold_rsp = 1'b0;
    bit          rand_tx = 1'b0;
    bit          cti_pending = 1'b0;
    int          force_bc = -1;
    int          delivered = 0;
    int          n_flush = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        if (imem.exists(pc)) return imem[pc];
        return {pc[26:2], 7'h13};
    endfunction

    function automatic bit opc_is_cti(input logic [31:0] inst);
        return (inst[6:0] == 7'b1101111) || (inst[6:0] == 7'b1100111) ||
               (inst[6:0] == 7'b1100011);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (ifu_rx_valid && ifu_rx_ready) begin
                check("bus_req", {31'd0, bus_req_valid, bus_req_addr}, {31'd0, 1'b1, ifu_rx_pc});
                exp_q.push_back({ifu_rx_pc, inst_of(ifu_rx_pc)});
            end else begin
                check("bus_idle", {63'd0, bus_req_valid}, 64'd0);
            end
            if (bus_req_valid) begin
                rsp_pc_q.push_back(bus_req_addr);
                rsp_due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
            end
            if (ifu_tx_valid && ifu_tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got pc 0x%0h inst 0x%0h expected no pair",
                             ifu_tx_pc, ifu_tx_inst);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("tx_pair", {ifu_tx_pc, ifu_tx_inst}, e);
                    delivered++;
                    if (opc_is_cti(e[31:0])) cti_pending = 1'b1;
                end
            end
        end
    end

    // Bus responder: in-order responses, latency >= 1 cycle.
    initial begin
        bus_rsp_valid = 1'b0;
        bus_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus_rsp_valid = 1'b0;
            if (!rstn) begin
                rsp_pc_q.delete();
                rsp_due_q.delete();
            end else if (!hold_rsp && rsp_pc_q.size() > 0 && rsp_due_q[0] <= cyc) begin
                bus_rsp_valid = 1'b1;
                bus_rsp_data  = inst_of(rsp_pc_q.pop_front());
                void'(rsp_due_q.pop_front());
            end
        end
    end

    // IDU back-pressure in the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_tx) ifu_tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Branch resolver: after a CTI is delivered, resolve it; a redirect
    // discards everything fetched behind it.
    initial begin
        ifu_rx_pc_valid = 1'b0;
        ifu_rx_bc_en    = 1'b0;
        forever begin
            wait (cti_pending);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            ifu_rx_pc_valid = 1'b1;
            ifu_rx_bc_en    = (force_bc < 0) ? 1'($urandom_range(0, 1)) : 1'(force_bc);
            if (ifu_rx_bc_en) begin
                n_flush++;
                exp_q.delete();
            end
            cti_pending = 1'b0;
            @(posedge clk);
            #1;
            ifu_rx_pc_valid = 1'b0;
            ifu_rx_bc_en    = 1'b0;
        end
    end

    // Driver tasks (entered and left at posedge + 1)
    task automatic send_pc(input logic [31:0] pc);
        int t;
        bit acc;
        t   = 0;
        acc = 1'b0;
        ifu_rx_valid = 1'b1;
        ifu_rx_pc    = pc;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = ifu_rx_ready;
            t++;
            @(posedge clk);
            #1;
        end
        ifu_rx_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: pc 0x%0h not accepted after %0d cycles", pc, t);
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && rsp_pc_q.size() == 0 && !cti_pending &&
                 !ifu_rx_pc_valid && dbg_state == RX_PEND) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(negedge clk);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_state"}, 64'(dbg_state), 64'(RX_PEND));
        check({name, "_occ"}, 64'(dbg_occ), 64'd0);
        @(posedge clk);
        #1;
    endtask

    int d0;

    initial begin
        rstn         = 1'b0;
        ifu_rx_valid = 1'b0;
        ifu_rx_pc    = '0;
        ifu_tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_tx_valid", {63'd0, ifu_tx_valid}, 64'd0);
        check("rst_rx_ready", {63'd0, ifu_rx_ready}, 64'd1);
        check("rst_bus_req", {63'd0, bus_req_valid}, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(RX_PEND));
        check("rst_occ", 64'(dbg_occ), 64'd0);
        @(posedge clk);
        #1;

        // Three sequential PCs at 2-cycle latency
        d0 = delivered;
        send_pc(32'h0);
        send_pc(32'h4);
        send_pc(32'h8);
        wait_idle("seq");
        check("seq_count", 64'(delivered - d0), 64'd3);

        // IDU stall holds head pair and blocks accepts
        d0 = delivered;
        hold_rsp = 1'b1;
        send_pc(32'h100);
        send_pc(32'h104);
        send_pc(32'h108);
        ifu_tx_ready = 1'b0;
        hold_rsp = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        repeat (3) begin
            @(negedge clk);
            check("stall_rx_ready", {63'd0, ifu_rx_ready}, 64'd0);
            check("stall_tx_valid", {63'd0, ifu_tx_valid}, 64'd1);
            check("stall_head", {ifu_tx_pc, ifu_tx_inst}, {32'h100, inst_of(32'h100)});
        end
        @(posedge clk);
        #1;
        ifu_tx_ready = 1'b1;
        wait_idle("stall");
        check("stall_count", 64'(delivered - d0), 64'd3);

        // Full: eight outstanding, ninth waits for a pop
        d0 = delivered;
        hold_rsp = 1'b1;
        for (int i = 0; i < DEPTH; i++) send_pc(32'h200 + 32'(4 * i));
        ifu_rx_valid = 1'b1;
        ifu_rx_pc    = 32'h220;
        repeat (4) begin
            @(negedge clk);
            check("full_rx_ready", {63'd0, ifu_rx_ready}, 64'd0);
            check("full_occ", 64'(dbg_occ), 64'(DEPTH));
        end
        @(posedge clk);
        #1;
        hold_rsp = 1'b0;
        send_pc(32'h220);
        wait_idle("full");
        check("full_count", 64'(delivered - d0), 64'(DEPTH + 1));

        // jal with fall-through resolution
        imem[32'h10] = 32'h0000006F;
        force_bc = 0;
        d0 = delivered;
        hold_rsp = 1'b1;
        send_pc(32'h10);
        send_pc(32'h14);
        send_pc(32'h18);
        hold_rsp = 1'b0;
        wait_idle("bc_ft");
        check("bc_ft_count", 64'(delivered - d0), 64'd3);

        // jal with redirect: younger pairs discarded
        force_bc = 1;
        d0 = delivered;
        hold_rsp = 1'b1;
        send_pc(32'h10);
        send_pc(32'h14);
        send_pc(32'h18);
        hold_rsp = 1'b0;
        wait_idle("bc_rd");
        check("bc_rd_count", 64'(delivered - d0), 64'd1);
        send_pc(32'h40);
        wait_idle("after_rd");
        check("after_rd_count", 64'(delivered - d0), 64'd2);

        // Randomized traffic
        force_bc = -1;
        lat_min  = 1;
        lat_max  = 4;
        rand_tx  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pc;
            logic [31:0] rv;
            pc = 32'h1000 + 32'(4 * i);
            rv = $urandom();
            case ($urandom_range(0, 9))
                0: imem[pc] = {rv[31:7], 7'b1101111};
                1: imem[pc] = {rv[31:7], 7'b1100111};
                2: imem[pc] = {rv[31:7], 7'b1100011};
                3: imem[pc] = {rv[31:7], 7'b0110011};
                default: imem[pc] = {rv[31:7], 7'b0010011};
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_pc(pc);
        end
        rand_tx = 1'b0;
        ifu_tx_ready = 1'b1;
        wait_idle("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #800000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
